// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// ID/EX issue register for an RV32I pipeline. It decodes the instruction
// arriving from decode/register-read into the ALU operation code, the ALU
// operand pair and the branch-compare tag, then registers everything as the
// ID/EX pipeline boundary. Stall holds the register and flush loads a bubble.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset (all outputs to 0)
//   id_valid       in   ID-stage inputs carry a real instruction
//   id_instr[31:0] in   instruction word
//   id_pc[31:0]    in   instruction address
//   id_rs1_data    in   forwarded rs1 value (32 bits)
//   id_rs2_data    in   forwarded rs2 value (32 bits)
//   stall          in   hold the ID/EX register
//   flush          in   squash the ID/EX register (wins over stall)
//   ex_valid       out  execute slot occupied
//   ex_aluctrl     out  ALU operation code (4 bits)
//   ex_src1        out  ALU operand 1 (32 bits)
//   ex_src2        out  ALU operand 2 (32 bits)
//   ex_store_data  out  rs2 value for stores (32 bits)
//   ex_rd          out  destination register (5 bits)
//   ex_regwrite    out  writeback enable
//   ex_branch      out  conditional branch in slot
//   ex_br_funct3   out  branch condition (funct3)
//   ex_jump        out  JAL/JALR in slot
//   ex_illegal     out  unsupported encoding in slot
// ---------------------------------------------------------------------------
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [3:0]  ex_aluctrl,
  output logic [31:0] ex_src1,
  output logic [31:0] ex_src2,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_branch,
  output logic [2:0]  ex_br_funct3,
  output logic        ex_jump,
  output logic        ex_illegal
);

  // ALU operation codes shared with the execute stage
  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b0001;
  localparam logic [3:0] AND  = 4'b0010;
  localparam logic [3:0] OR   = 4'b0011;
  localparam logic [3:0] XOR  = 4'b0100;
  localparam logic [3:0] SLL  = 4'b0101;
  localparam logic [3:0] SRL  = 4'b0110;
  localparam logic [3:0] SLT  = 4'b0111;
  localparam logic [3:0] SRA  = 4'b1000;
  localparam logic [3:0] SLTU = 4'b1001;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Everything that crosses the ID/EX boundary, kept together so a bubble
  // is a single all-zero assignment.
  typedef struct packed {
    logic        valid;
    logic [3:0]  aluctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        regwrite;
    logic        branch;
    logic [2:0]  br_funct3;
    logic        jump;
    logic        illegal;
  } ex_bundle_t;

  // funct3 -> ALU code for the funct7=0000000 register/immediate group
  function automatic logic [3:0] base_op(input logic [2:0] funct3);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = ADD;
      3'b001:  op = SLL;
      3'b010:  op = SLT;
      3'b011:  op = SLTU;
      3'b100:  op = XOR;
      3'b101:  op = SRL;
      3'b110:  op = OR;
      3'b111:  op = AND;
      default: op = ADD;
    endcase
    return op;
  endfunction

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [4:0]  rd_field_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_u_s;
  logic [31:0] shamt_s;

  assign opcode_s   = id_instr[6:0];
  assign funct3_s   = id_instr[14:12];
  assign funct7_s   = id_instr[31:25];
  assign rd_field_s = id_instr[11:7];
  assign imm_i_s    = {{20{id_instr[31]}}, id_instr[31:20]};
  assign imm_s_s    = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_u_s    = {id_instr[31:12], 12'b0};
  assign shamt_s    = {27'b0, id_instr[24:20]};

  logic        illegal_s;
  logic [3:0]  aluctrl_raw_s;
  logic [31:0] src1_raw_s;
  logic [31:0] src2_raw_s;
  logic [4:0]  rd_raw_s;
  logic        regwrite_raw_s;
  logic        branch_raw_s;
  logic        jump_raw_s;
  ex_bundle_t  dec_s;
  ex_bundle_t  ex_r;

  // Raw decode: operation, operands and control per opcode, plus legality
  always_comb begin
    illegal_s      = 1'b0;
    aluctrl_raw_s  = ADD;
    src1_raw_s     = 32'd0;
    src2_raw_s     = 32'd0;
    rd_raw_s       = 5'd0;
    regwrite_raw_s = 1'b0;
    branch_raw_s   = 1'b0;
    jump_raw_s     = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        src1_raw_s     = id_rs1_data;
        src2_raw_s     = id_rs2_data;
        rd_raw_s       = rd_field_s;
        regwrite_raw_s = 1'b1;
        if (funct7_s == F7_BASE) begin
          aluctrl_raw_s = base_op(funct3_s);
        end else if (funct7_s == F7_ALT && funct3_s == 3'b000) begin
          aluctrl_raw_s = SUB;
        end else if (funct7_s == F7_ALT && funct3_s == 3'b101) begin
          aluctrl_raw_s = SRA;
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        src1_raw_s     = id_rs1_data;
        rd_raw_s       = rd_field_s;
        regwrite_raw_s = 1'b1;
        if (funct3_s == 3'b001) begin
          src2_raw_s = shamt_s;
          if (funct7_s == F7_BASE) begin
            aluctrl_raw_s = SLL;
          end else begin
            illegal_s = 1'b1;
          end
        end else if (funct3_s == 3'b101) begin
          src2_raw_s = shamt_s;
          if (funct7_s == F7_BASE) begin
            aluctrl_raw_s = SRL;
          end else if (funct7_s == F7_ALT) begin
            aluctrl_raw_s = SRA;
          end else begin
            illegal_s = 1'b1;
          end
        end else begin
          src2_raw_s    = imm_i_s;
          aluctrl_raw_s = base_op(funct3_s);
        end
      end
      OPC_LUI: begin
        src2_raw_s     = imm_u_s;
        rd_raw_s       = rd_field_s;
        regwrite_raw_s = 1'b1;
      end
      OPC_AUIPC: begin
        src1_raw_s     = id_pc;
        src2_raw_s     = imm_u_s;
        rd_raw_s       = rd_field_s;
        regwrite_raw_s = 1'b1;
      end
      OPC_LOAD: begin
        src1_raw_s     = id_rs1_data;
        src2_raw_s     = imm_i_s;
        rd_raw_s       = rd_field_s;
        regwrite_raw_s = 1'b1;
      end
      OPC_STORE: begin
        src1_raw_s = id_rs1_data;
        src2_raw_s = imm_s_s;
      end
      OPC_BRANCH: begin
        src1_raw_s   = id_rs1_data;
        src2_raw_s   = id_rs2_data;
        branch_raw_s = 1'b1;
        case (funct3_s)
          3'b000, 3'b001: aluctrl_raw_s = SUB;
          3'b100, 3'b101: aluctrl_raw_s = SLT;
          3'b110, 3'b111: aluctrl_raw_s = SLTU;
          default:        illegal_s     = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        // ALU computes the link value pc+4; the target is resolved elsewhere
        src1_raw_s     = id_pc;
        src2_raw_s     = 32'd4;
        rd_raw_s       = rd_field_s;
        regwrite_raw_s = 1'b1;
        jump_raw_s     = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Final bundle: illegal slots become a valid, inert ADD 0,0 with no side
  // effects; writes to x0 are suppressed.
  always_comb begin
    dec_s            = '0;
    dec_s.valid      = 1'b1;
    dec_s.store_data = id_rs2_data;
    if (illegal_s) begin
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.aluctrl   = aluctrl_raw_s;
      dec_s.src1      = src1_raw_s;
      dec_s.src2      = src2_raw_s;
      dec_s.rd        = rd_raw_s;
      dec_s.regwrite  = regwrite_raw_s && (rd_raw_s != 5'd0);
      dec_s.branch    = branch_raw_s;
      dec_s.br_funct3 = branch_raw_s ? funct3_s : 3'b000;
      dec_s.jump      = jump_raw_s;
    end
  end

  // ID/EX register: rst > flush > stall > load (bubble when id_valid=0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r <= '0;
    end else if (flush) begin
      ex_r <= '0;
    end else if (!stall) begin
      ex_r <= id_valid ? dec_s : '0;
    end
  end

  assign ex_valid      = ex_r.valid;
  assign ex_aluctrl    = ex_r.aluctrl;
  assign ex_src1       = ex_r.src1;
  assign ex_src2       = ex_r.src2;
  assign ex_store_data = ex_r.store_data;
  assign ex_rd         = ex_r.rd;
  assign ex_regwrite   = ex_r.regwrite;
  assign ex_branch     = ex_r.branch;
  assign ex_br_funct3  = ex_r.br_funct3;
  assign ex_jump       = ex_r.jump;
  assign ex_illegal    = ex_r.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed self-checking bench for alu_issue_stage. Each vector is driven
// just after a rising edge, clocked through the ID/EX register and the
// outputs are compared 1 time unit after the following rising edge against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_aluctrl;
  logic [31:0] ex_src1;
  logic [31:0] ex_src2;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_branch;
  logic [2:0]  ex_br_funct3;
  logic        ex_jump;
  logic        ex_illegal;

  int error_count;
  int check_count;

  alu_issue_stage dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_aluctrl    (ex_aluctrl),
    .ex_src1       (ex_src1),
    .ex_src2       (ex_src2),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_regwrite   (ex_regwrite),
    .ex_branch     (ex_branch),
    .ex_br_funct3  (ex_br_funct3),
    .ex_jump       (ex_jump),
    .ex_illegal    (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count = check_count + 1;
    if (obs !== exp) begin
      error_count = error_count + 1;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    id_valid    = v;
    id_instr    = instr;
    id_pc       = pc;
    id_rs1_data = rs1;
    id_rs2_data = rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check every output in one go
  task automatic check_all(input string tag, input logic v, input logic [3:0] op,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                           input logic br, input logic [2:0] bf3, input logic jmp,
                           input logic ill);
    check_eq({tag, ".valid"},    ex_valid,      v);
    check_eq({tag, ".aluctrl"},  ex_aluctrl,    op);
    check_eq({tag, ".src1"},     ex_src1,       s1);
    check_eq({tag, ".src2"},     ex_src2,       s2);
    check_eq({tag, ".store"},    ex_store_data, sd);
    check_eq({tag, ".rd"},       ex_rd,         rd);
    check_eq({tag, ".regwrite"}, ex_regwrite,   rw);
    check_eq({tag, ".branch"},   ex_branch,     br);
    check_eq({tag, ".brf3"},     ex_br_funct3,  bf3);
    check_eq({tag, ".jump"},     ex_jump,       jmp);
    check_eq({tag, ".illegal"},  ex_illegal,    ill);
  endtask

  initial begin
    error_count = 0;
    check_count = 0;
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0000_0000, 32'h0, 32'h0, 32'h0);
    #1 rst = 1'b1;
    #1;
    check_all("reset", 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // ADD x3,x1,x2
    drive(1'b1, 32'h0020_81B3, 32'h0, 32'd5, 32'd7);
    tick();
    check_all("add", 1'b1, 4'b0000, 32'd5, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // SRAI x5,x6,3
    drive(1'b1, 32'h4033_5293, 32'h0, 32'h8000_0000, 32'h55);
    tick();
    check_all("srai", 1'b1, 4'b1000, 32'h8000_0000, 32'd3, 32'h55, 5'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // SRAI with funct7=0010000 is illegal
    drive(1'b1, 32'h2033_5293, 32'h0, 32'h8000_0000, 32'h55);
    tick();
    check_all("srai_bad", 1'b1, 4'b0000, 32'h0, 32'h0, 32'h55, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

    // BLTU x1,x2
    drive(1'b1, 32'h0020_E063, 32'h40, 32'd1, 32'hFFFF_FFFF);
    tick();
    check_all("bltu", 1'b1, 4'b1001, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0);

    // funct3=010 branch is illegal
    drive(1'b1, 32'h0020_A063, 32'h40, 32'd1, 32'd2);
    tick();
    check_eq("beq010.illegal", ex_illegal, 1'b1);
    check_eq("beq010.branch",  ex_branch,  1'b0);
    check_eq("beq010.valid",   ex_valid,   1'b1);

    // LUI x1,0x12345: src1 is 0 regardless of rs1
    drive(1'b1, 32'h1234_50B7, 32'h0, 32'hDEAD_BEEF, 32'h0);
    tick();
    check_all("lui", 1'b1, 4'b0000, 32'h0, 32'h1234_5000, 32'h0, 5'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // AUIPC x1,0x12345 at pc=0x100
    drive(1'b1, 32'h1234_5097, 32'h100, 32'hDEAD_BEEF, 32'h0);
    tick();
    check_eq("auipc.src1", ex_src1, 32'h100);
    check_eq("auipc.src2", ex_src2, 32'h1234_5000);
    check_eq("auipc.rd",   ex_rd,   5'd1);

    // LW x4,-4(x1): sign-extended I-immediate
    drive(1'b1, 32'hFFC0_A203, 32'h0, 32'h1000, 32'h77);
    tick();
    check_all("lw", 1'b1, 4'b0000, 32'h1000, 32'hFFFF_FFFC, 32'h77, 5'd4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // SW x2,8(x1): S-immediate, no rd, no writeback
    drive(1'b1, 32'h0020_A423, 32'h0, 32'h2000, 32'hCAFE_F00D);
    tick();
    check_all("sw", 1'b1, 4'b0000, 32'h2000, 32'd8, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // JAL x1 at pc=0x200: link value pc+4
    drive(1'b1, 32'h0000_00EF, 32'h200, 32'h0, 32'h0);
    tick();
    check_all("jal", 1'b1, 4'b0000, 32'h200, 32'd4, 32'h0, 5'd1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);

    // ADD x0,x1,x2: writeback suppressed
    drive(1'b1, 32'h0020_8033, 32'h0, 32'd5, 32'd7);
    tick();
    check_eq("add_x0.regwrite", ex_regwrite, 1'b0);
    check_eq("add_x0.rd",       ex_rd,       5'd0);

    // SUB x3,x1,x2
    drive(1'b1, 32'h4020_81B3, 32'h0, 32'd9, 32'd4);
    tick();
    check_eq("sub.aluctrl", ex_aluctrl, 4'b0001);

    // Stall sequence: load ADD, then hold for 3 cycles while inputs change
    drive(1'b1, 32'h0020_81B3, 32'h0, 32'd5, 32'd7);
    tick();
    stall = 1'b1;
    drive(1'b1, 32'h1234_50B7, 32'h0, 32'h11, 32'h22);
    tick();
    drive(1'b1, 32'h4033_5293, 32'h0, 32'h33, 32'h44);
    tick();
    drive(1'b0, 32'h0000_00EF, 32'h300, 32'h0, 32'h0);
    tick();
    check_all("stall", 1'b1, 4'b0000, 32'd5, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // Flush wins over stall
    drive(1'b1, 32'h0020_81B3, 32'h0, 32'd5, 32'd7);
    flush = 1'b1;
    tick();
    check_all("flush", 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // No stall/flush, id_valid=0: bubble persists
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 32'h0020_81B3, 32'h0, 32'd5, 32'd7);
    tick();
    check_all("bubble", 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // MUL (M-extension) is illegal
    drive(1'b1, 32'h0220_8133, 32'h0, 32'd6, 32'd3);
    tick();
    check_all("mul", 1'b1, 4'b0000, 32'h0, 32'h0, 32'd3, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

    // Load a full slot, then reset mid-cycle: outputs clear before any edge
    drive(1'b1, 32'h0020_81B3, 32'h0, 32'd5, 32'd7);
    tick();
    check_eq("pre_rst.valid", ex_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-to-execute issue register. It is the producing end of the ALU control interface.
- Decodes a 32-bit RV32I instruction into the ALU opcode, operand pair and branch-compare tags consumed by the execute stage.
- Registers all of them as the ID/EX pipeline boundary, with stall (hold) and flush (bubble) control.
- Sits between the decode/register-file read stage and the execute-stage ALU. The ALU consumes `ex_aluctrl`/`ex_src1`/`ex_src2`; branch resolution consumes `ex_br_funct3` together with the ALU's zero/lstBit flags.

Parameters:
- ADD, 4'b0000, ALU add code
- SUB, 4'b0001, ALU subtract code
- AND, 4'b0010, ALU and code
- OR, 4'b0011, ALU or code
- XOR, 4'b0100, ALU xor code
- SLL, 4'b0101, ALU shift-left-logical code
- SRL, 4'b0110, ALU shift-right-logical code
- SLT, 4'b0111, ALU signed set-less-than code
- SRA, 4'b1000, ALU shift-right-arithmetic code
- SLTU, 4'b1001, ALU unsigned set-less-than code

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  id_instr/id_pc/id_rs1_data/id_rs2_data hold a real instruction
- id_instr  in  32  instruction word
- id_pc  in  32  instruction address
- id_rs1_data  in  32  forwarded rs1 value
- id_rs2_data  in  32  forwarded rs2 value
- stall  in  1  hold ID/EX register
- flush  in  1  squash ID/EX register
- ex_valid  out  1  execute slot occupied
- ex_aluctrl  out  4  ALU operation code
- ex_src1  out  32  ALU operand 1
- ex_src2  out  32  ALU operand 2
- ex_store_data  out  32  rs2 value for stores
- ex_rd  out  5  destination register
- ex_regwrite  out  1  writeback enable
- ex_branch  out  1  conditional branch in slot
- ex_br_funct3  out  3  branch condition (funct3)
- ex_jump  out  1  JAL/JALR in slot
- ex_illegal  out  1  unsupported encoding

Behaviour:
- All outputs registered; latency exactly 1 cycle from ID inputs to EX outputs.
- Reset (async, rst=1): all outputs 0, which gives `ex_aluctrl`=ADD.
- Per-edge priority: rst > flush > stall > load.
  - flush=1, including when stall=1: load bubble.
  - stall=1 and flush=0: hold all outputs.
  - Otherwise, with id_valid=0: load bubble.
  - Otherwise: load decoded values.
- Bubble: all outputs 0.

Decode by opcode (instr[6:0]):
- OP 0110011: src1=rs1, src2=rs2. Operation selected by funct3/funct7:
  - funct7=0000000: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: only 000 SUB, 101 SRA.
  - Any other funct7 (including M-extension 0000001): illegal.
- OP-IMM 0010011: src2 = sign-extended I-immediate, same funct3 map.
  - Shifts use src2={27'b0, shamt}.
  - funct3=001 requires funct7=0000000.
  - funct3=101 requires funct7 0000000 (SRL) or 0100000 (SRA).
  - Anything else is illegal.
- LUI 0110111: src1=0, src2={instr[31:12],12'b0}, ADD.
- AUIPC 0010111: src1=pc, src2=U-immediate, ADD.
- LOAD 0000011: src1=rs1, src2=I-immediate, ADD, regwrite=1.
- STORE 0100011: src1=rs1, src2=S-immediate, ADD, regwrite=0.
- BRANCH 1100011: src1=rs1, src2=rs2, branch=1, regwrite=0, br_funct3=funct3.
  - 000/001 SUB; 100/101 SLT; 110/111 SLTU.
  - 010/011 illegal.
- JAL 1101111, JALR 1100111: src1=pc, src2=32'd4, ADD, jump=1, regwrite=1 (link value).
- Any other opcode: illegal.

Output rules:
- ex_store_data = rs2 for every loaded instruction.
- ex_rd=instr[11:7] for formats with rd, else 0.
- ex_regwrite forced 0 when rd=0.
- Illegal: ex_valid=1, ex_illegal=1, ex_aluctrl=ADD, src1=src2=0, regwrite=0, branch=0, jump=0.
- ex_illegal is 0 on bubbles.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle: valid=1, aluctrl=0000, src1=5, src2=7, rd=3, regwrite=1.
- SRAI x5,x6,3 (0x40335293) -> aluctrl=1000, src2=3, rd=5, regwrite=1. Changing funct7 to 0x10 -> illegal=1, regwrite=0.
- BLTU funct3=110, rs1=1, rs2=0xFFFFFFFF -> aluctrl=1001, branch=1, br_funct3=110, regwrite=0.
- LUI x1,0x12345 (0x123450B7) -> src1=0, src2=0x12345000, aluctrl=0000, rd=1. Then AUIPC with pc=0x100 -> src1=0x100.
- Sequence: load ADD; stall=1 for 3 cycles while id_instr changes -> outputs unchanged. Then stall=1 with flush=1 -> bubble (all outputs 0). Then stall=0, id_valid=0 -> bubble persists.
- MUL (0x02208133) -> illegal=1, valid=1, regwrite=0. Assert rst mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
